// File: rtl/pie_burst_encoder.sv
// Pulse-interval burst encoder: serialises a word MSB-first as pulse bursts
// (ZERO_PULSES for 0, ONE_PULSES for 1), each burst followed by a low gap.
module pie_burst_encoder #(
  parameter int DATA_W      = 4,
  parameter int PERIOD_CLKS = 2,
  parameter int HIGH_CLKS   = 1,
  parameter int ZERO_PULSES = 5,
  parameter int ONE_PULSES  = 10,
  parameter int GAP_PERIODS = 3
) (
  input  logic              sclk_3mhz,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              zcd_pulse,
  output logic              busy,
  output logic              bit_done,
  output logic              frame_done
);
  localparam int PW = $clog2(PERIOD_CLKS + 1);
  localparam int CW = $clog2(ONE_PULSES + 1);
  localparam int GW = $clog2(GAP_PERIODS + 1);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [PW-1:0] PH_LAST  = PW'(PERIOD_CLKS - 1);
  localparam logic [PW-1:0] PH_HIGH  = PW'(HIGH_CLKS);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_PERIODS - 1);
  localparam logic [BW-1:0] BIT_TOP  = BW'(DATA_W - 1);
  localparam logic [CW-1:0] ONE_LAST = CW'(ONE_PULSES - 1);
  localparam logic [CW-1:0] ZER_LAST = CW'(ZERO_PULSES - 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] sreg, sreg_nx;
  logic [BW-1:0]     bit_cnt, bit_cnt_nx;
  logic [PW-1:0]     phase, phase_nx;
  logic [CW-1:0]     pulse_cnt, pulse_cnt_nx;
  logic [GW-1:0]     gap_cnt, gap_cnt_nx;
  logic [CW-1:0]     pulse_last;
  logic              phase_wrap;
  logic              pulse_nx, bit_done_nx, frame_done_nx;

  assign data_ready = (state == IDLE);
  assign phase_wrap = (phase == PH_LAST);
  assign pulse_last = sreg[DATA_W-1] ? ONE_LAST : ZER_LAST;

  always_comb begin
    state_nx     = state;
    sreg_nx      = sreg;
    bit_cnt_nx   = bit_cnt;
    phase_nx     = phase;
    pulse_cnt_nx = pulse_cnt;
    gap_cnt_nx   = gap_cnt;
    case (state)
      IDLE: begin
        if (data_valid) begin
          state_nx     = BURST;
          sreg_nx      = data_in;
          bit_cnt_nx   = BIT_TOP;
          phase_nx     = '0;
          pulse_cnt_nx = '0;
          gap_cnt_nx   = '0;
        end
      end
      BURST: begin
        if (!phase_wrap) begin
          phase_nx = phase + 1'b1;
        end else if (pulse_cnt == pulse_last) begin
          state_nx     = GAP;
          phase_nx     = '0;
          pulse_cnt_nx = '0;
          gap_cnt_nx   = '0;
        end else begin
          phase_nx     = '0;
          pulse_cnt_nx = pulse_cnt + 1'b1;
        end
      end
      GAP: begin
        if (!phase_wrap) begin
          phase_nx = phase + 1'b1;
        end else if (gap_cnt != GAP_LAST) begin
          phase_nx   = '0;
          gap_cnt_nx = gap_cnt + 1'b1;
        end else begin
          phase_nx     = '0;
          pulse_cnt_nx = '0;
          gap_cnt_nx   = '0;
          if (bit_cnt == '0) begin
            state_nx = IDLE;
          end else begin
            state_nx   = BURST;
            sreg_nx    = sreg << 1;
            bit_cnt_nx = bit_cnt - 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the flops present each
  // cycle's value in the same cycle the counters describe.
  assign pulse_nx      = (state_nx == BURST) && (phase_nx < PH_HIGH);
  assign bit_done_nx   = (state_nx == GAP) && (gap_cnt_nx == GAP_LAST) && (phase_nx == PH_LAST);
  assign frame_done_nx = bit_done_nx && (bit_cnt_nx == '0);

  always_ff @(posedge sclk_3mhz) begin
    if (reset) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      phase      <= '0;
      pulse_cnt  <= '0;
      gap_cnt    <= '0;
      zcd_pulse  <= 1'b0;
      busy       <= 1'b0;
      bit_done   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      sreg       <= sreg_nx;
      bit_cnt    <= bit_cnt_nx;
      phase      <= phase_nx;
      pulse_cnt  <= pulse_cnt_nx;
      gap_cnt    <= gap_cnt_nx;
      zcd_pulse  <= pulse_nx;
      busy       <= (state_nx != IDLE);
      bit_done   <= bit_done_nx;
      frame_done <= frame_done_nx;
    end
  end
endmodule
